// File: rtl/wb_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_master_arbiter_pkg
//  Purpose  : Shared state encodings and limits for the Wishbone master
//             arbiter and its round-robin picker.
//  Revision : 1.0  initial release
// ============================================================================
package wb_master_arbiter_pkg;

    // Largest requester count the picker and muxes are sized for
    localparam int c_max_masters = 8;

    // Arbiter states with an explicit two-bit encoding
    typedef enum logic [1:0] {
        WBARB_IDLE = 2'd0,
        WBARB_OWN  = 2'd1,
        WBARB_ERR  = 2'd2
    } arb_state_t;

    // Watchdog counter width; a disabled watchdog still keeps one bit
    function automatic int wdog_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_master_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : wb_master_arbiter_rr_pick
//  Purpose  : Combinational round-robin picker. Returns the first requester
//             found scanning upward from i_ptr+1, wrapping back to i_ptr.
//  Revision : 1.0  initial release
// ============================================================================
module wb_master_arbiter_rr_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int PTR_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [PTR_W-1:0]       i_ptr,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [PTR_W-1:0]       o_idx,
    output logic                   o_valid
);

    // Two passes: masters above the pointer first, then the wrapped range
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!o_valid && (i > int'(i_ptr)) && i_req[i]) begin
                o_valid    = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!o_valid && (i <= int'(i_ptr)) && i_req[i]) begin
                o_valid    = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = PTR_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_master_arbiter
//  Purpose  : Shares one Wishbone B4 classic slave port between several CPU
//             side masters. Round-robin grant held for a whole CYC tenure;
//             a watchdog ends stalled strobes with a one-cycle ERR.
//  Revision : 1.0  initial release
// ============================================================================
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK_I,
    input  logic                      RST_N_I,
    input  logic [NUM_MASTERS-1:0]    M_CYC_I,
    input  logic [NUM_MASTERS-1:0]    M_STB_I,
    input  logic [NUM_MASTERS-1:0]    M_WE_I,
    input  logic [4*NUM_MASTERS-1:0]  M_SEL_I,
    input  logic [32*NUM_MASTERS-1:0] M_ADR_I,
    input  logic [32*NUM_MASTERS-1:0] M_DAT_I,
    output logic [31:0]               M_DAT_O,
    output logic [NUM_MASTERS-1:0]    M_ACK_O,
    output logic [NUM_MASTERS-1:0]    M_ERR_O,
    output logic                      S_CYC_O,
    output logic                      S_STB_O,
    output logic                      S_WE_O,
    output logic [3:0]                S_SEL_O,
    output logic [31:0]               S_ADR_O,
    output logic [31:0]               S_DAT_O,
    input  logic                      S_ACK_I,
    input  logic [31:0]               S_DAT_I,
    output logic [NUM_MASTERS-1:0]    O_grant
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int WDOG_W = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] c_wdog_limit = WDOG_W'(TIMEOUT_CYCLES);
    localparam logic c_wdog_en = (TIMEOUT_CYCLES > 0);

    generate
        if (NUM_MASTERS < 2 || NUM_MASTERS > c_max_masters) begin : g_bad_n
            $error("wb_master_arbiter: NUM_MASTERS out of range");
        end
    endgenerate

    arb_state_t              r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0]  r_grant, w_grant_nxt;
    logic [PTR_W-1:0]        r_ptr, w_ptr_nxt;
    logic [WDOG_W-1:0]       r_wdog, w_wdog_nxt;

    logic [NUM_MASTERS-1:0]  w_pick_grant;
    logic [PTR_W-1:0]        w_pick_idx;
    logic                    w_pick_valid;

    logic [3:0]              w_sel [NUM_MASTERS];
    logic [31:0]             w_adr [NUM_MASTERS];
    logic [31:0]             w_dat [NUM_MASTERS];

    logic                    w_own, w_owner_cyc, w_stall, w_err;

    // Split the packed per-master buses into indexable arrays
    generate
        for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_unpack
            assign w_sel[m] = M_SEL_I[4*m +: 4];
            assign w_adr[m] = M_ADR_I[32*m +: 32];
            assign w_dat[m] = M_DAT_I[32*m +: 32];
        end
    endgenerate

    wb_master_arbiter_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .PTR_W       (PTR_W)
    ) u_pick (
        .i_req   (M_CYC_I),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Slave-side mux: the pointer holds the owner index during a tenure
    always_comb begin
        w_own       = (r_state == WBARB_OWN);
        w_owner_cyc = M_CYC_I[r_ptr];
        S_CYC_O     = w_own & w_owner_cyc;
        S_STB_O     = S_CYC_O & M_STB_I[r_ptr];
        S_WE_O      = w_own & M_WE_I[r_ptr];
        S_SEL_O     = w_own ? w_sel[r_ptr] : 4'h0;
        S_ADR_O     = w_own ? w_adr[r_ptr] : 32'h0;
        S_DAT_O     = w_own ? w_dat[r_ptr] : 32'h0;
        M_DAT_O     = S_DAT_I;
        w_stall     = S_STB_O & ~S_ACK_I;
        // ACK on the limit cycle wins because ERR needs ACK low
        w_err       = c_wdog_en & w_stall & (r_wdog == c_wdog_limit);
        M_ACK_O     = r_grant & {NUM_MASTERS{S_ACK_I & S_STB_O}};
        M_ERR_O     = r_grant & {NUM_MASTERS{w_err}};
        O_grant     = r_grant;
    end

    // Next-state, grant/pointer and watchdog update
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_wdog_nxt  = '0;
        case (r_state)
            WBARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = WBARB_OWN;
                    w_grant_nxt = w_pick_grant;
                    w_ptr_nxt   = w_pick_idx;
                end
            end
            WBARB_OWN: begin
                if (!w_owner_cyc) begin
                    w_state_nxt = WBARB_IDLE;
                    w_grant_nxt = '0;
                end else if (w_err) begin
                    w_state_nxt = WBARB_ERR;
                end else if (w_stall) begin
                    w_wdog_nxt = (r_wdog == c_wdog_limit) ? r_wdog : r_wdog + 1'b1;
                end
            end
            WBARB_ERR: begin
                if (!w_owner_cyc) begin
                    w_state_nxt = WBARB_IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = WBARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State registers; pointer starts at the last master so master 0 wins first
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state <= WBARB_IDLE;
            r_grant <= '0;
            r_ptr   <= PTR_W'(NUM_MASTERS - 1);
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_master_arbiter
//  Purpose  : Self-checking bench for wb_master_arbiter (2 masters, timeout 4)
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_master_arbiter;

    localparam int N  = 2;
    localparam int TO = 4;

    logic            CLK_I = 1'b0;
    logic            RST_N_I;
    logic [N-1:0]    M_CYC_I, M_STB_I, M_WE_I;
    logic [4*N-1:0]  M_SEL_I;
    logic [32*N-1:0] M_ADR_I, M_DAT_I;
    logic [31:0]     M_DAT_O;
    logic [N-1:0]    M_ACK_O, M_ERR_O, O_grant;
    logic            S_CYC_O, S_STB_O, S_WE_O;
    logic [3:0]      S_SEL_O;
    logic [31:0]     S_ADR_O, S_DAT_O;
    logic            S_ACK_I;
    logic [31:0]     S_DAT_I;

    always #5 CLK_I = ~CLK_I;

    wb_master_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .CLK_I(CLK_I), .RST_N_I(RST_N_I),
        .M_CYC_I(M_CYC_I), .M_STB_I(M_STB_I), .M_WE_I(M_WE_I),
        .M_SEL_I(M_SEL_I), .M_ADR_I(M_ADR_I), .M_DAT_I(M_DAT_I),
        .M_DAT_O(M_DAT_O), .M_ACK_O(M_ACK_O), .M_ERR_O(M_ERR_O),
        .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O),
        .S_SEL_O(S_SEL_O), .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O),
        .S_ACK_I(S_ACK_I), .S_DAT_I(S_DAT_I), .O_grant(O_grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic apply_reset();
        RST_N_I = 1'b0;
        M_CYC_I = '1; M_STB_I = '1; M_WE_I = '1; S_ACK_I = 1'b1;
        M_SEL_I = '1; M_ADR_I = {32'h0000_0200, 32'h0000_0100};
        M_DAT_I = '1; S_DAT_I = 32'h0;
        repeat (3) @(posedge CLK_I);
        #2;
        chk("rst_grant", 32'(O_grant), 32'h0);
        chk("rst_scyc",  32'(S_CYC_O), 32'h0);
        chk("rst_sstb",  32'(S_STB_O), 32'h0);
        chk("rst_adr",   S_ADR_O, 32'h0);
        chk("rst_ack",   32'(M_ACK_O), 32'h0);
        chk("rst_err",   32'(M_ERR_O), 32'h0);
        M_CYC_I = '0; M_STB_I = '0; M_WE_I = '0; S_ACK_I = 1'b0;
        RST_N_I = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic [1:0]  grant;
        logic        scyc;
        logic        sstb;
        logic [1:0]  mack;
        logic [1:0]  merr;
        logic        adr_chk;
        logic [31:0] adr;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] cyc, input logic [1:0] stb, input logic ack,
                                input logic [1:0] g, input logic sc, input logic ss,
                                input logic [1:0] ma, input logic [1:0] me,
                                input logic ac, input logic [31:0] adr);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.ack = ack; v.grant = g; v.scyc = sc; v.sstb = ss;
        v.mack = ma; v.merr = me; v.adr_chk = ac; v.adr = adr;
        return v;
    endfunction

    vec_t tbl [29];

    // Reference model state (owner = -1 when nobody holds the bus)
    int   owner, last, stall;
    bit   in_err;
    logic [N-1:0]  r_cyc;
    logic [31:0]   adr_a [N];
    logic [31:0]   dat_a [N];
    logic [3:0]    sel_a [N];

    initial begin
        // cycle-by-cycle sequence from reset: cyc stb ack | grant scyc sstb ack err adrchk adr
        tbl[0]  = mk(2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 32'h0);
        tbl[1]  = mk(2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[2]  = mk(2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[3]  = mk(2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[4]  = mk(2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 2'b00, 1, 32'h100);
        tbl[5]  = mk(2'b10, 2'b10, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1, 32'h100);
        tbl[6]  = mk(2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 32'h0);
        tbl[7]  = mk(2'b10, 2'b10, 1, 2'b10, 1, 1, 2'b10, 2'b00, 1, 32'h200);
        tbl[8]  = mk(2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00, 1, 32'h200);
        tbl[9]  = mk(2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00, 1, 32'h200);
        tbl[10] = mk(2'b11, 2'b01, 0, 2'b10, 1, 0, 2'b00, 2'b00, 1, 32'h200);
        tbl[11] = mk(2'b01, 2'b01, 0, 2'b10, 0, 0, 2'b00, 2'b00, 1, 32'h200);
        tbl[12] = mk(2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 32'h0);
        tbl[13] = mk(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[14] = mk(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[15] = mk(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[16] = mk(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[17] = mk(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b01, 1, 32'h100);
        tbl[18] = mk(2'b01, 2'b01, 1, 2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        tbl[19] = mk(2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        tbl[20] = mk(2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 32'h0);
        tbl[21] = mk(2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 32'h0);
        tbl[22] = mk(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[23] = mk(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[24] = mk(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[25] = mk(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 32'h100);
        tbl[26] = mk(2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 2'b00, 1, 32'h100);
        tbl[27] = mk(2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1, 32'h100);
        tbl[28] = mk(2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 32'h0);

        // ---------------- table-driven sequence ----------------
        apply_reset();
        M_ADR_I = {32'h0000_0200, 32'h0000_0100};
        M_SEL_I = 8'hC3;
        M_DAT_I = {32'hBBBB_0001, 32'hAAAA_0000};
        for (int i = 0; i < 29; i++) begin
            M_CYC_I = tbl[i].cyc;
            M_STB_I = tbl[i].stb;
            S_ACK_I = tbl[i].ack;
            S_DAT_I = $urandom;
            #1;
            chk($sformatf("t%0d_grant", i), 32'(O_grant), 32'(tbl[i].grant));
            chk($sformatf("t%0d_scyc", i),  32'(S_CYC_O), 32'(tbl[i].scyc));
            chk($sformatf("t%0d_sstb", i),  32'(S_STB_O), 32'(tbl[i].sstb));
            chk($sformatf("t%0d_ack", i),   32'(M_ACK_O), 32'(tbl[i].mack));
            chk($sformatf("t%0d_err", i),   32'(M_ERR_O), 32'(tbl[i].merr));
            chk($sformatf("t%0d_mdat", i),  M_DAT_O, S_DAT_I);
            if (tbl[i].adr_chk)
                chk($sformatf("t%0d_adr", i), S_ADR_O, tbl[i].adr);
            tick();
        end

        // ---------------- reset asserted in the middle of a tenure ----------------
        M_CYC_I = 2'b10; M_STB_I = 2'b10; S_ACK_I = 1'b1;
        for (int i = 0; i < 5 && O_grant !== 2'b10; i++) tick();
        chk("midrst_setup_grant", 32'(O_grant), 32'h2);
        chk("midrst_setup_ack",   32'(M_ACK_O), 32'h2);
        #2;
        RST_N_I = 1'b0;
        #1;
        chk("midrst_grant", 32'(O_grant), 32'h0);
        chk("midrst_scyc",  32'(S_CYC_O), 32'h0);
        chk("midrst_sstb",  32'(S_STB_O), 32'h0);
        chk("midrst_ack",   32'(M_ACK_O), 32'h0);
        chk("midrst_adr",   S_ADR_O, 32'h0);
        tick();
        RST_N_I = 1'b1;

        // ---------------- randomized run against the behavioural model ----------------
        apply_reset();
        owner = -1; last = N - 1; stall = 0; in_err = 0;
        r_cyc = '0;
        begin
            int ack_mode;
            ack_mode = 0;
            for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
                logic [N-1:0] stb, we;
                logic         ack;
                logic [N-1:0] e_grant, e_ack, e_err;
                logic         e_scyc, e_sstb, own;
                if (cyc_n % 250 == 0) ack_mode = $urandom_range(0, 2);
                for (int m = 0; m < N; m++) begin
                    if ($urandom_range(0, 15) == 0) r_cyc[m] = ~r_cyc[m];
                    stb[m]   = r_cyc[m] & ($urandom_range(0, 3) != 0);
                    we[m]    = 1'($urandom);
                    sel_a[m] = 4'($urandom);
                    adr_a[m] = $urandom;
                    dat_a[m] = $urandom;
                    M_SEL_I[4*m +: 4]   = sel_a[m];
                    M_ADR_I[32*m +: 32] = adr_a[m];
                    M_DAT_I[32*m +: 32] = dat_a[m];
                end
                case (ack_mode)
                    0:       ack = ($urandom_range(0, 1) == 0);
                    1:       ack = ($urandom_range(0, 5) == 0);
                    default: ack = ($urandom_range(0, 40) == 0);
                endcase
                M_CYC_I = r_cyc; M_STB_I = stb; M_WE_I = we; S_ACK_I = ack;
                S_DAT_I = $urandom;
                #1;
                // expected outputs from the current model state
                own     = (owner >= 0) && !in_err;
                e_grant = '0;
                if (owner >= 0) e_grant[owner] = 1'b1;
                e_scyc  = own && r_cyc[owner];
                e_sstb  = e_scyc && stb[owner];
                e_ack   = (e_sstb && ack) ? e_grant : '0;
                e_err   = (e_sstb && !ack && stall == TO) ? e_grant : '0;
                chk("rnd_grant", 32'(O_grant), 32'(e_grant));
                chk("rnd_scyc",  32'(S_CYC_O), 32'(e_scyc));
                chk("rnd_sstb",  32'(S_STB_O), 32'(e_sstb));
                chk("rnd_ack",   32'(M_ACK_O), 32'(e_ack));
                chk("rnd_err",   32'(M_ERR_O), 32'(e_err));
                chk("rnd_mdat",  M_DAT_O, S_DAT_I);
                chk("rnd_excl",  32'($countones(M_ACK_O | M_ERR_O) <= 1 && (M_ACK_O & M_ERR_O) == '0), 32'h1);
                if (!in_err) begin
                    chk("rnd_adr", S_ADR_O, own ? adr_a[owner] : 32'h0);
                    chk("rnd_sdat", S_DAT_O, own ? dat_a[owner] : 32'h0);
                    chk("rnd_sel", 32'(S_SEL_O), own ? 32'(sel_a[owner]) : 32'h0);
                    chk("rnd_we",  32'(S_WE_O),  own ? 32'(we[owner]) : 32'h0);
                end
                // advance the model across the clock edge
                if (owner < 0) begin
                    for (int k = 1; k <= N && owner < 0; k++) begin
                        int idx;
                        idx = (last + k) % N;
                        if (r_cyc[idx]) begin
                            owner = idx;
                            last  = idx;
                        end
                    end
                end else if (!r_cyc[owner]) begin
                    owner = -1; in_err = 0; stall = 0;
                end else if (in_err) begin
                    stall = 0;
                end else if (e_err != '0) begin
                    in_err = 1; stall = 0;
                end else if (e_sstb && !ack) begin
                    stall = (stall < TO) ? stall + 1 : TO;
                end else begin
                    stall = 0;
                end
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
